lsu_mem_port: RTL and testbench
===============================

// Module: lsu_mem_port
// PURPOSE
//  Load/store unit between decode/regfile and data memory. Takes a load/store instr with its rs1/rs2 data.
//  Computes the effective address and issues one valid/ready memory request.
//  Loads: aligns and extends the response, then drives the regfile write port (w_en/rd_id/rd_write_data).
//  Other end of the regfile interface: consumes the read ports, produces the write port.
// PARAMETERS
//  RESP_TIMEOUT  256  max cycles in RESP waiting for mem_resp_valid_i before aborting (>=1)
// PORTS
//  clk               in   1   single clock, all state on posedge
//  rst_n             in   1   reset, asynchronous, active-low
//  start_i           in   1   1-cycle pulse: instr_i/rs1/rs2 valid, begin operation
//  instr_i           in   32  RV32I instruction (opcode 0000011 load / 0100011 store)
//  rs1_rdata_i       in   32  base register value
//  rs2_rdata_i       in   32  store data register value
//  busy_o            out  1   state != IDLE
//  done_o            out  1   1-cycle pulse: operation finished (any outcome)
//  misaligned_o      out  1   pulse with done_o: misaligned access, nothing issued
//  timeout_o         out  1   pulse with done_o: load response timed out
//  mem_req_valid_o   out  1   request valid
//  mem_req_ready_i   in   1   memory accepts request
//  mem_req_addr_o    out  32  word-aligned address {ea[31:2],2'b00}
//  mem_req_we_o      out  1   1=store
//  mem_req_wstrb_o   out  4   byte enables (0 for loads)
//  mem_req_wdata_o   out  32  lane-replicated store data (0 for loads)
//  mem_resp_valid_i  in   1   load data valid
//  mem_resp_rdata_i  in   32  load word
//  w_en_o            out  1   regfile write enable
//  rd_id_o           out  5   regfile destination
//  rd_write_data_o   out  32  regfile write data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0; async assertion drops mem_req_valid_o at once.
//  States: IDLE -> (start) CHK -> REQ -> store: DONE | load: RESP -> WB -> IDLE.
//  IDLE: start_i captures instr fields, rs1, rs2; start_i ignored in any other state.
//  CHK (1 cycle): ea = rs1 + sext(imm); imm is I-type for loads, S-type for stores; 32-bit wrap, no overflow flag.
//   Misaligned (h/hu/sh with ea[0]; w/sw with ea[1:0]!=0) -> done_o+misaligned_o, no request, to IDLE.
//   Non-load/store opcode or undefined funct3 -> done_o only, no request/write, to IDLE.
//  REQ: valid=1; addr/we/wstrb/wdata held stable until posedge with valid&&ready; valid drops next cycle.
//   sb: wstrb=1<<ea[1:0], wdata={4{rs2[7:0]}}; sh: wstrb=ea[1]?1100:0011, wdata={2{rs2[15:0]}}; sw: 1111, rs2.
//  Stores posted: done_o asserted in the cycle after handshake (DONE state), no response awaited.
//  RESP: counter increments each cycle; mem_resp_valid_i captures rdata -> WB.
//   Counter reaching RESP_TIMEOUT without response -> done_o+timeout_o, no write, to IDLE.
//   Response and timeout in same cycle: response wins.
//  mem_resp_valid_i outside RESP (late/spurious) ignored.
//  Extract: byte = rdata[8*ea[1:0]+:8], half = rdata[16*ea[1]+:16]; lb/lh sign-extend, lbu/lhu zero-extend.
//  WB (1 cycle): done_o=1; w_en_o=1 only if rd!=0; rd_id_o/rd_write_data_o hold last value otherwise.
//  Latency, load, ready=1, resp same cycle after accept: start -> done/w_en 4 cycles later.
//  start_i coincident with done_o: ignored (not IDLE).
// TESTING
//  1 lw x5,4 (0x0040A283), rs1=0x1000, resp 0xDEADBEEF 3 cyc after accept
//     -> addr 0x1004 we=0; w_en=1 rd=5 data 0xDEADBEEF, one done.
//  2 lb rd=6 imm=3, rs1=0x1000, rdata 0x80112233 -> 0xFFFFFF80; same as lbu -> 0x00000080.
//  3 sh imm=2, rs1=0x2000, rs2=0x0000ABCD, ready low 4 cyc
//     -> addr 0x2000 wstrb 1100 wdata 0xABCDABCD stable; done cycle after accept; no w_en.
//  4 lw ea=0x1002 -> done+misaligned next cycle, mem_req_valid never 1; lw rd=x0 -> done, w_en=0.
//  5 RESP_TIMEOUT=8, no response -> done+timeout after 8 RESP cycles, w_en=0; resp 2 cyc later ignored.
//  6 rst_n low during RESP -> all outputs 0 immediately; following lw completes normally.

Source files
------------

// File: rtl/lsu_mem_port_if.sv
// Data-memory request/response bus for the load/store unit.
// Valid/ready request channel plus an unconditioned load response.
interface lsu_mem_port_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [3:0]  mem_req_wstrb;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_rdata;

   modport master (
      output mem_req_valid,
      output mem_req_addr,
      output mem_req_we,
      output mem_req_wstrb,
      output mem_req_wdata,
      input  mem_req_ready,
      input  mem_resp_valid,
      input  mem_resp_rdata
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_addr,
      input  mem_req_we,
      input  mem_req_wstrb,
      input  mem_req_wdata,
      output mem_req_ready,
      output mem_resp_valid,
      output mem_resp_rdata
   );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit: address generation, one memory request,
// load alignment/extension and regfile write-back.
module lsu_mem_port #(
   parameter int RESP_TIMEOUT = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic [31:0]   instr_i,
   input  logic [31:0]   rs1_rdata_i,
   input  logic [31:0]   rs2_rdata_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          misaligned_o,
   output logic          timeout_o,
   lsu_mem_port_if.master mem,
   output logic          w_en_o,
   output logic [4:0]    rd_id_o,
   output logic [31:0]   rd_write_data_o
);
   localparam int CW = $clog2(RESP_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(RESP_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, CHK, REQ, DONE, RESP, WB
   } state_t;

   state_t state, nxt;

   logic [31:0]   instr_q, rs1_q, rs2_q;
   logic [31:0]   ea_q, wdata_q, rd_data_q;
   logic [3:0]    wstrb_q;
   logic          we_q;
   logic [4:0]    rd_id_q;
   logic [CW-1:0] cnt;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [4:0]  rd;
   logic        is_ld, is_st;
   logic        sz_b, sz_h, sz_w;
   logic        legal, mis;
   logic [31:0] imm, ea;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic [7:0]  bsel;
   logic [15:0] hsel;
   logic [31:0] ld_val;
   logic        req_v, done, mis_p, tmo_p;

   assign opc   = instr_q[6:0];
   assign f3    = instr_q[14:12];
   assign rd    = instr_q[11:7];
   assign is_ld = (opc == 7'b0000011);
   assign is_st = (opc == 7'b0100011);

   assign imm = is_st
      ? {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]}
      : {{20{instr_q[31]}}, instr_q[31:20]};
   assign ea  = rs1_q + imm;

   assign sz_b = (f3[1:0] == 2'b00);
   assign sz_h = (f3[1:0] == 2'b01);
   assign sz_w = (f3[1:0] == 2'b10);

   // Loads allow unsigned b/h (funct3 4,5); stores only 0..2.
   assign legal =
      (is_ld && f3 != 3'd3 && f3[2:1] != 2'b11) ||
      (is_st && !f3[2] && f3[1:0] != 2'b11);
   assign mis =
      (sz_h && ea[0]) ||
      (sz_w && ea[1:0] != 2'b00);

   always_comb begin
      wstrb = '0;
      wdata = '0;
      unique case (1'b1)
         sz_b: begin
            wstrb = 4'b0001 << ea[1:0];
            wdata = {4{rs2_q[7:0]}};
         end
         sz_h: begin
            wstrb = ea[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rs2_q[15:0]}};
         end
         sz_w: begin
            wstrb = 4'b1111;
            wdata = rs2_q;
         end
         default: ;
      endcase
   end

   assign bsel =
      mem.mem_resp_rdata[{ea_q[1:0], 3'b000} +: 8];
   assign hsel =
      mem.mem_resp_rdata[{ea_q[1], 4'b0000} +: 16];

   always_comb begin
      ld_val = mem.mem_resp_rdata;
      unique case (f3)
         3'b000:  ld_val = {{24{bsel[7]}}, bsel};
         3'b100:  ld_val = {24'd0, bsel};
         3'b001:  ld_val = {{16{hsel[15]}}, hsel};
         3'b101:  ld_val = {16'd0, hsel};
         default: ld_val = mem.mem_resp_rdata;
      endcase
   end

   always_comb begin
      nxt   = state;
      req_v = 1'b0;
      done  = 1'b0;
      mis_p = 1'b0;
      tmo_p = 1'b0;
      unique case (state)
         IDLE: if (start_i) nxt = CHK;
         CHK: begin
            if (!legal) begin
               done = 1'b1;
               nxt  = IDLE;
            end else if (mis) begin
               done  = 1'b1;
               mis_p = 1'b1;
               nxt   = IDLE;
            end else begin
               nxt = REQ;
            end
         end
         REQ: begin
            req_v = 1'b1;
            if (mem.mem_req_ready)
               nxt = we_q ? DONE : RESP;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         // A response in the final cycle beats the timeout.
         RESP: begin
            if (mem.mem_resp_valid) begin
               nxt = WB;
            end else if (cnt == LAST) begin
               done  = 1'b1;
               tmo_p = 1'b1;
               nxt   = IDLE;
            end
         end
         WB: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q   <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         ea_q      <= '0;
         we_q      <= 1'b0;
         wstrb_q   <= '0;
         wdata_q   <= '0;
         cnt       <= '0;
         rd_id_q   <= '0;
         rd_data_q <= '0;
      end else begin
         if (state == IDLE && start_i) begin
            instr_q <= instr_i;
            rs1_q   <= rs1_rdata_i;
            rs2_q   <= rs2_rdata_i;
         end
         if (state == CHK && legal && !mis) begin
            ea_q    <= ea;
            we_q    <= is_st;
            wstrb_q <= is_st ? wstrb : 4'b0000;
            wdata_q <= is_st ? wdata : 32'd0;
         end
         cnt <= (state == RESP && nxt == RESP)
            ? cnt + 1'b1 : '0;
         if (state == RESP && mem.mem_resp_valid
             && rd != 5'd0) begin
            rd_id_q   <= rd;
            rd_data_q <= ld_val;
         end
      end
   end

   assign mem.mem_req_valid = req_v;
   assign mem.mem_req_addr  = {ea_q[31:2], 2'b00};
   assign mem.mem_req_we    = we_q;
   assign mem.mem_req_wstrb = wstrb_q;
   assign mem.mem_req_wdata = wdata_q;

   assign busy_o          = (state != IDLE);
   assign done_o          = done;
   assign misaligned_o    = mis_p;
   assign timeout_o       = tmo_p;
   assign w_en_o          = (state == WB) && (rd != 5'd0);
   assign rd_id_o         = rd_id_q;
   assign rd_write_data_o = rd_data_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized bench for lsu_mem_port against an
// arithmetic reference model of the load/store rules.
module tb_lsu_mem_port;
   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] instr_i = '0;
   logic [31:0] rs1_rdata_i = '0;
   logic [31:0] rs2_rdata_i = '0;
   logic        busy_o, done_o, misaligned_o, timeout_o;
   logic        w_en_o;
   logic [4:0]  rd_id_o;
   logic [31:0] rd_write_data_o;

   int checks = 0;
   int errors = 0;
   logic [4:0]  last_rd = '0;
   logic [31:0] last_data = '0;

   lsu_mem_port_if mem();

   lsu_mem_port #(.RESP_TIMEOUT(TMO)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_i         (start_i),
      .instr_i         (instr_i),
      .rs1_rdata_i     (rs1_rdata_i),
      .rs2_rdata_i     (rs2_rdata_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .misaligned_o    (misaligned_o),
      .timeout_o       (timeout_o),
      .mem             (mem),
      .w_en_o          (w_en_o),
      .rd_id_o         (rd_id_o),
      .rd_write_data_o (rd_write_data_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h",
                  tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_ld(
      input logic [4:0] rd, input logic [2:0] f3,
      input logic [11:0] imm);
      return {imm, 5'd1, f3, rd, 7'b0000011};
   endfunction

   function automatic logic [31:0] enc_st(
      input logic [2:0] f3, input logic [11:0] imm);
      return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0],
              7'b0100011};
   endfunction

   task automatic run_op(input logic [31:0] ins,
                         input logic [31:0] r1,
                         input logic [31:0] r2,
                         input logic [31:0] rdat,
                         input int rdly,
                         input int rspd,
                         input bit hold);
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] imm, ea, e_wd, e_ld;
      logic [3:0]  e_strb;
      bit   is_ld, is_st, legal, e_mis, e_req, e_tmo, e_wen;
      int   sz, off, acc_e, e_dcyc;
      longint v, full;
      int   vcnt, acc, dcnt, dcyc, wcnt;
      bit   mis_s, tmo_s, unst, we_s;
      logic [31:0] a_s, wd_s, wr_d;
      logic [3:0]  st_s;
      logic [4:0]  wr_rd;

      f3    = ins[14:12];
      rd    = ins[11:7];
      is_ld = (ins[6:0] == 7'b0000011);
      is_st = (ins[6:0] == 7'b0100011);
      imm   = is_st
         ? {{20{ins[31]}}, ins[31:25], ins[11:7]}
         : {{20{ins[31]}}, ins[31:20]};
      sz    = 1 << f3[1:0];
      legal = is_ld ? (f3 inside {0, 1, 2, 4, 5})
            : is_st ? (f3 inside {0, 1, 2}) : 1'b0;
      ea    = r1 + imm;
      off   = int'(ea % 4);
      e_mis = legal && (ea % sz != 0);
      e_req = legal && !e_mis;
      e_strb = 4'(((1 << sz) - 1) << off);
      e_wd  = (sz == 1) ? (r2 & 32'hFF) * 32'h01010101
            : (sz == 2) ? (r2 & 32'hFFFF) * 32'h00010001
            : r2;
      v = longint'(rdat >> (8 * off));
      if (sz < 4) begin
         full = longint'(1) << (8 * sz);
         v = v % full;
         if (!f3[2] && v >= full / 2) v = v - full;
      end
      e_ld  = 32'(v);
      e_tmo = e_req && is_ld && rspd > TMO;
      e_wen = e_req && is_ld && !e_tmo && rd != 5'd0;
      acc_e = 2 + rdly;
      e_dcyc = !e_req ? 1
             : is_st ? acc_e + 1
             : e_tmo ? acc_e + TMO
             : acc_e + rspd + 1;

      vcnt = 0; acc = -1; dcnt = 0; dcyc = -1; wcnt = 0;
      mis_s = 0; tmo_s = 0; unst = 0; we_s = 0;
      a_s = '0; wd_s = '0; st_s = '0;
      wr_rd = '0; wr_d = '0;

      @(negedge clk);
      for (int k = 0; k < 80; k++) begin
         start_i     = (k == 0) || (hold && dcnt == 0);
         instr_i     = start_i ? ins : $urandom;
         rs1_rdata_i = start_i ? r1 : $urandom;
         rs2_rdata_i = start_i ? r2 : $urandom;
         mem.mem_req_ready  = (vcnt >= rdly);
         mem.mem_resp_valid = (acc >= 0 && k == acc + rspd);
         mem.mem_resp_rdata = mem.mem_resp_valid
            ? rdat : $urandom;
         #1;
         if (mem.mem_req_valid) begin
            if (vcnt == 0) begin
               a_s  = mem.mem_req_addr;
               we_s = mem.mem_req_we;
               st_s = mem.mem_req_wstrb;
               wd_s = mem.mem_req_wdata;
            end else if (a_s !== mem.mem_req_addr
                         || we_s !== mem.mem_req_we
                         || st_s !== mem.mem_req_wstrb
                         || wd_s !== mem.mem_req_wdata) begin
               unst = 1;
            end
            vcnt++;
            if (mem.mem_req_ready && acc < 0) acc = k;
         end
         if (done_o) begin
            dcnt++;
            dcyc = k;
         end
         mis_s |= misaligned_o;
         tmo_s |= timeout_o;
         if (w_en_o) begin
            wcnt++;
            wr_rd = rd_id_o;
            wr_d  = rd_write_data_o;
         end
         @(negedge clk);
         if (dcnt > 0 && k >= dcyc + 4) break;
      end
      start_i = 0;
      mem.mem_req_ready  = 0;
      mem.mem_resp_valid = 0;

      check("done_cnt", dcnt, 1);
      check("done_cyc", dcyc, e_dcyc);
      check("misaligned", 32'(mis_s), 32'(e_mis));
      check("timeout", 32'(tmo_s), 32'(e_tmo));
      check("req_cycles", vcnt, e_req ? rdly + 1 : 0);
      if (e_req) begin
         check("addr", a_s, ea & 32'hFFFF_FFFC);
         check("we", 32'(we_s), 32'(is_st));
         check("wstrb", 32'(st_s),
               is_st ? 32'(e_strb) : 32'd0);
         check("wdata", wd_s, is_st ? e_wd : 32'd0);
         check("stable", 32'(unst), 0);
      end
      check("wen_cnt", wcnt, e_wen ? 1 : 0);
      if (e_wen) begin
         check("wr_rd", 32'(wr_rd), 32'(rd));
         check("wr_data", wr_d, e_ld);
         last_rd   = rd;
         last_data = e_ld;
      end
      check("rd_id_hold", 32'(rd_id_o), 32'(last_rd));
      check("rd_data_hold", rd_write_data_o, last_data);
      check("busy_end", 32'(busy_o), 0);
   endtask

   initial begin
      logic [31:0] ins, r1, imm32;
      logic [2:0]  f3;
      logic [11:0] imm;
      int kind;

      mem.mem_req_ready  = 0;
      mem.mem_resp_valid = 0;
      mem.mem_resp_rdata = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_valid", 32'(mem.mem_req_valid), 0);
      check("rst_outs", 32'({done_o, misaligned_o,
            timeout_o, w_en_o, rd_id_o}), 0);
      check("rst_addr", mem.mem_req_addr, 0);
      rst_n = 1;

      run_op(32'h0040A283, 32'h1000, 32'h0,
             32'hDEADBEEF, 0, 3, 0);
      run_op(enc_ld(5'd6, 3'b000, 12'd3), 32'h1000, 32'h0,
             32'h80112233, 0, 1, 0);
      run_op(enc_ld(5'd6, 3'b100, 12'd3), 32'h1000, 32'h0,
             32'h80112233, 0, 1, 1);
      run_op(enc_st(3'b001, 12'd2), 32'h2000, 32'h0000ABCD,
             32'h0, 4, 1, 0);
      run_op(enc_ld(5'd5, 3'b010, 12'd2), 32'h1000, 32'h0,
             32'h0, 0, 1, 0);
      run_op(enc_ld(5'd0, 3'b010, 12'd4), 32'h1000, 32'h0,
             32'h12345678, 0, 2, 0);
      run_op(enc_ld(5'd9, 3'b010, 12'd0), 32'h1000, 32'h0,
             32'h11111111, 1, TMO + 2, 0);
      run_op(enc_ld(5'd10, 3'b001, 12'hFFE), 32'h1004,
             32'h0, 32'hA5A58001, 0, TMO, 1);
      run_op(32'h00000013, 32'h1000, 32'h0,
             32'h0, 0, 1, 0);
      run_op(enc_ld(5'd11, 3'b011, 12'd0), 32'h1000,
             32'h0, 32'h0, 0, 1, 0);
      run_op(enc_st(3'b000, 12'hFFF), 32'h0,
             32'h000000C3, 32'h0, 2, 1, 1);

      @(negedge clk);
      start_i = 1;
      instr_i = enc_ld(5'd7, 3'b010, 12'd0);
      rs1_rdata_i = 32'h3000;
      mem.mem_req_ready = 1;
      @(negedge clk);
      start_i = 0;
      repeat (3) @(negedge clk);
      #2 rst_n = 0;
      #1;
      check("arst_valid", 32'(mem.mem_req_valid), 0);
      check("arst_busy", 32'(busy_o), 0);
      check("arst_outs", 32'({done_o, misaligned_o,
            timeout_o, w_en_o, rd_id_o, mem.mem_req_we,
            mem.mem_req_wstrb}), 0);
      check("arst_data", rd_write_data_o
            | mem.mem_req_addr | mem.mem_req_wdata, 0);
      mem.mem_req_ready = 0;
      @(negedge clk);
      rst_n = 1;
      last_rd = '0;
      last_data = '0;
      run_op(enc_ld(5'd7, 3'b010, 12'd8), 32'h3000, 32'h0,
             32'hCAFEF00D, 0, 1, 0);

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 9);
         f3   = 3'($urandom_range(0, 7));
         imm  = 12'($urandom);
         if ($urandom_range(0, 1) == 1) imm[1:0] = 2'b00;
         r1 = $urandom;
         if ($urandom_range(0, 1) == 1) r1[1:0] = 2'b00;
         imm32 = $urandom;
         if (kind < 5)
            ins = enc_ld(5'($urandom_range(0, 31)), f3, imm);
         else if (kind < 9)
            ins = enc_st(f3, imm);
         else
            ins = {imm32[31:7], 7'b0110011};
         run_op(ins, r1, $urandom, $urandom,
                $urandom_range(0, 3),
                $urandom_range(1, TMO + 3),
                bit'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
